// File: rtl/seq_match_monitor_if.sv
`default_nettype none
// ============================================================================
//  Module   : seq_match_monitor_if
//  Purpose  : Status-bus bundle between the detector side and the monitor.
//             The detector side drives PAT/CLR; the monitor drives the
//             HIT/COUNT/LED/ERR observation outputs.
//  Revision : 1.0  initial release
// ============================================================================
interface seq_match_monitor_if #(
   parameter int CNT_W = 16
);
   logic [7:0]       PAT;
   logic             CLR;
   logic             HIT;
   logic [CNT_W-1:0] COUNT;
   logic [7:0]       LED;
   logic             ERR;

   // Detector / board side
   modport master (
      output PAT, CLR,
      input  HIT, COUNT, LED, ERR
   );

   // Monitor side
   modport slave (
      input  PAT, CLR,
      output HIT, COUNT, LED, ERR
   );
endinterface
`default_nettype wire

// File: rtl/seq_match_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : seq_match_monitor
//  Purpose  : Watches the detector status bus for the detect pattern, emits
//             one HIT pulse per new detection, keeps a saturating count,
//             stretches each detection into an LED flash and latches a sticky
//             fault on any unexpected bus value.
//  Revision : 1.0  initial release
// ============================================================================
module seq_match_monitor #(
   parameter logic [7:0]  DET_PATTERN  = 8'hAA,
   parameter logic [7:0]  IDLE_PATTERN = 8'h55,
   parameter int unsigned STRETCH_LEN  = 1000,
   parameter int          CNT_W        = 16
) (
   input  wire logic             CK,
   input  wire logic             R,
   seq_match_monitor_if.slave    bus
);

   localparam int         TMR_W  = 24;
   localparam logic [TMR_W-1:0] RELOAD = TMR_W'(STRETCH_LEN - 1);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_STRETCH = 2'd1;
   localparam logic [1:0] ST_FAULT   = 2'd2;

   localparam logic [7:0] LED_OFF   = 8'h00;
   localparam logic [7:0] LED_FLASH = 8'hFF;
   localparam logic [7:0] LED_FAULT = 8'h81;

   logic [7:0]       pat_q;
   logic [7:0]       pat_prev;
   logic [1:0]       state;
   logic [1:0]       state_next;
   logic [TMR_W-1:0] timer;
   logic [TMR_W-1:0] timer_next;

   logic             hit_now;
   logic             illegal_now;

   logic             hit_q;
   logic [CNT_W-1:0] count_q;
   logic [7:0]       led_q;
   logic             err_q;

   logic             hit_d;
   logic [CNT_W-1:0] count_d;
   logic [7:0]       led_d;
   logic             err_d;

   // Rising edge of the detect pattern; both history registers reset to the
   // idle value so that coming out of reset can never look like an edge.
   assign hit_now     = (pat_q == DET_PATTERN) && (pat_prev != DET_PATTERN);
   assign illegal_now = (pat_q != DET_PATTERN) && (pat_q != IDLE_PATTERN);

   // Two-stage capture of the status bus.
   always_ff @(posedge CK or negedge R) begin
      if (!R) begin
         pat_q    <= IDLE_PATTERN;
         pat_prev <= IDLE_PATTERN;
      end else begin
         pat_q    <= bus.PAT;
         pat_prev <= pat_q;
      end
   end

   // State and flash timer registers.
   always_ff @(posedge CK or negedge R) begin
      if (!R) begin
         state <= ST_IDLE;
         timer <= '0;
      end else begin
         state <= state_next;
         timer <= timer_next;
      end
   end

   // Next-state logic; a fault outranks a retrigger, and CLR masks a
   // simultaneous illegal value so the fault re-arms on the next one.
   always_comb begin
      state_next = state;
      timer_next = timer;
      case (state)
         ST_IDLE: begin
            if (illegal_now && !bus.CLR) begin
               state_next = ST_FAULT;
               timer_next = '0;
            end else if (hit_now) begin
               state_next = ST_STRETCH;
               timer_next = RELOAD;
            end
         end
         ST_STRETCH: begin
            if (illegal_now && !bus.CLR) begin
               state_next = ST_FAULT;
               timer_next = '0;
            end else if (hit_now) begin
               timer_next = RELOAD;
            end else if (timer == '0) begin
               state_next = ST_IDLE;
            end else begin
               timer_next = timer - 1'b1;
            end
         end
         ST_FAULT: begin
            if (bus.CLR) begin
               state_next = ST_IDLE;
               timer_next = '0;
            end
         end
         default: begin
            state_next = ST_IDLE;
            timer_next = '0;
         end
      endcase
   end

   // Output values for the coming edge; LED follows the next state so the
   // flash appears on the same edge as the HIT pulse.
   always_comb begin
      hit_d = hit_now;
      if (bus.CLR)
         count_d = '0;
      else if (hit_now && (count_q != {CNT_W{1'b1}}))
         count_d = count_q + 1'b1;
      else
         count_d = count_q;
      err_d = (state_next == ST_FAULT);
      case (state_next)
         ST_STRETCH: led_d = LED_FLASH;
         ST_FAULT:   led_d = LED_FAULT;
         default:    led_d = LED_OFF;
      endcase
   end

   // Registered outputs; nothing reaches a port combinationally from PAT.
   always_ff @(posedge CK or negedge R) begin
      if (!R) begin
         hit_q   <= 1'b0;
         count_q <= '0;
         led_q   <= LED_OFF;
         err_q   <= 1'b0;
      end else begin
         hit_q   <= hit_d;
         count_q <= count_d;
         led_q   <= led_d;
         err_q   <= err_d;
      end
   end

   assign bus.HIT   = hit_q;
   assign bus.COUNT = count_q;
   assign bus.LED   = led_q;
   assign bus.ERR   = err_q;

endmodule
`default_nettype wire
